tag_match_encoder: RTL and testbench
====================================

// Module: tag_match_encoder
// PURPOSE
//   Per-way tag comparator bank plus one-hot-to-binary priority encoder for the
//   set-associative L2 lookup path. Compares the request tag against the stored
//   tags of every way in the indexed set, qualifies each match with the way's
//   valid bit, and encodes the matching way into a binary way index.
//   Registers the results for the hit/miss logic and the data-select multiplexor.
// PARAMETERS
//   WAYS      8   number of ways (>=2, power of two); one comparator per way
//   TAG_BITS  12  width of the address tag field
//   WAY_BITS  $clog2(WAYS)  derived; width of encoded way index (3 at default)
// PORTS
//   clk           in   1                  single clock; all state on rising edge
//   reset         in   1                  synchronous, active-high
//   lookup_valid  in   1                  request strobe; inputs sampled this cycle
//   addr_tag      in   TAG_BITS           tag field of request address
//   way_tags      in   WAYS*TAG_BITS      stored tags; way i at [i*TAG_BITS +: TAG_BITS]
//   way_valid     in   WAYS               per-way valid (MESI state != Invalid)
//   result_valid  out  1                  one-cycle pulse: registered result ready
//   match_vec     out  WAYS               registered qualified-match vector, bit i = way i
//   hit           out  1                  registered OR of match_vec
//   way_sel       out  WAY_BITS           registered binary index of lowest matching way
//   multi_hit     out  1                  registered: more than one way matched (error)
// BEHAVIOUR
//   - Comparator i (combinational): eq[i] = (way_tags slice i == addr_tag) & way_valid[i].
//     Full TAG_BITS equality; no partial or masked compare.
//   - Encoder (combinational): lowest-index set bit of eq wins; all-zero input -> index 0.
//   - multi-hit detect: eq has two or more bits set (popcount > 1).
//   - Latency: 1 cycle. lookup_valid=1 at edge N -> at edge N result_valid<=1,
//     match_vec<=eq, hit<=|eq, way_sel<=encode(eq), multi_hit<=popcount(eq)>1.
//   - lookup_valid=0 at an edge: result_valid<=0; match_vec, hit, way_sel and
//     multi_hit hold their previous values.
//   - Back-to-back lookups every cycle are supported; no stall, no backpressure.
//   - Miss (eq all zero): hit=0, way_sel=0, multi_hit=0, match_vec=0.
//   - Tag equal but way_valid[i]=0: no match for way i.
//   - Multi-hit: hit=1, match_vec shows all matches, way_sel=lowest index, multi_hit=1.
//   - Reset (takes priority over lookup_valid in the same cycle): all outputs <= 0.
//     A lookup presented in a reset cycle is dropped; no result_valid follows.
//   - No X propagation: all outputs are defined after the first reset edge.
// TESTING
//   1 Reset: hold reset 2 cycles with lookup_valid=1 -> all outputs 0, result_valid stays 0.
//   2 Single hit: addr_tag=12'hABC, way 5 tag=12'hABC, way_valid=8'hFF, other tags
//     differ -> next edge: result_valid=1, hit=1, way_sel=3'd5, match_vec=8'h20, multi_hit=0.
//   3 Invalid match: way 2 tag=addr_tag, way_valid=8'hFB ->
//     hit=0, way_sel=0, match_vec=8'h00.
//   4 Multi-hit: ways 3 and 6 match and are valid -> match_vec=8'h48, way_sel=3'd3,
//     hit=1, multi_hit=1.
//   5 Hold and streaming: lookups on 3 consecutive cycles (hit way 7, miss, hit way 0)
//     -> results on the following 3 edges with way_sel 7,0,0 and hit 1,0,1; then
//     lookup_valid=0 -> result_valid=0, other outputs hold the last value.
//   6 Boundary tags: addr_tag=12'hFFF vs stored 12'hFFE in every way, and addr_tag=0
//     vs stored 0 in way 0 only -> first case miss; second case hit, way_sel=0.

Source files
------------

// File: rtl/tag_match_encoder.sv
// Per-way tag comparator bank with a lowest-index priority encoder and
// multi-hit detection; results are registered one cycle after lookup_valid.
module tag_match_encoder #(
  parameter int WAYS     = 8,
  parameter int TAG_BITS = 12,
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lookup_valid,
  input  logic [TAG_BITS-1:0]      addr_tag,
  input  logic [WAYS*TAG_BITS-1:0] way_tags,
  input  logic [WAYS-1:0]          way_valid,
  output logic                     result_valid,
  output logic [WAYS-1:0]          match_vec,
  output logic                     hit,
  output logic [WAY_BITS-1:0]      way_sel,
  output logic                     multi_hit
);

  // Handshake: lookup_valid is a one-cycle strobe with no ready; every strobe
  // yields exactly one result_valid pulse on the following edge, so the
  // consumer must accept a result every cycle.

  logic [WAYS-1:0]     eq;
  logic [WAY_BITS-1:0] enc_idx;
  logic                eq_multi;

  always_comb begin
    eq = '0;
    for (int i = 0; i < WAYS; i++) begin
      eq[i] = (way_tags[i*TAG_BITS +: TAG_BITS] == addr_tag) & way_valid[i];
    end
  end

  // Scan high to low so the lowest set bit is the last write and wins.
  always_comb begin
    enc_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (eq[i]) enc_idx = WAY_BITS'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign eq_multi = |(eq & (eq - WAYS'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      result_valid <= 1'b0;
      match_vec    <= '0;
      hit          <= 1'b0;
      way_sel      <= '0;
      multi_hit    <= 1'b0;
    end else begin
      result_valid <= lookup_valid;
      if (lookup_valid) begin
        match_vec <= eq;
        hit       <= |eq;
        way_sel   <= enc_idx;
        multi_hit <= eq_multi;
      end
    end
  end

endmodule

// File: tb/tb_tag_match_encoder.sv
// Directed bench for tag_match_encoder: each scenario task drives a lookup and
// checks the registered outputs one edge later against hand-computed values.
module tb_tag_match_encoder;

  localparam int WAYS     = 8;
  localparam int TAG_BITS = 12;
  localparam int WAY_BITS = 3;

  logic                     clk;
  logic                     reset;
  logic                     lookup_valid;
  logic [TAG_BITS-1:0]      addr_tag;
  logic [WAYS*TAG_BITS-1:0] way_tags;
  logic [WAYS-1:0]          way_valid;
  logic                     result_valid;
  logic [WAYS-1:0]          match_vec;
  logic                     hit;
  logic [WAY_BITS-1:0]      way_sel;
  logic                     multi_hit;

  int n_checks = 0;
  int n_fail   = 0;

  tag_match_encoder #(.WAYS(WAYS), .TAG_BITS(TAG_BITS)) dut (
    .clk(clk),
    .reset(reset),
    .lookup_valid(lookup_valid),
    .addr_tag(addr_tag),
    .way_tags(way_tags),
    .way_valid(way_valid),
    .result_valid(result_valid),
    .match_vec(match_vec),
    .hit(hit),
    .way_sel(way_sel),
    .multi_hit(multi_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view {result_valid, hit, way_sel, match_vec, multi_hit}
  logic [13:0] obs;
  assign obs = {result_valid, hit, way_sel, match_vec, multi_hit};

  task automatic set_all_tags(input logic [TAG_BITS-1:0] t);
    for (int i = 0; i < WAYS; i++) way_tags[i*TAG_BITS +: TAG_BITS] = t;
  endtask

  task automatic set_tag(input int way, input logic [TAG_BITS-1:0] t);
    way_tags[way*TAG_BITS +: TAG_BITS] = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    lookup_valid = 1'b1;
    addr_tag     = 12'h123;
    set_all_tags(12'h123);
    way_valid    = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (obs !== 14'h0) begin
        n_fail++;
        $display("FAIL reset_cycle%0d: got %h expected %h", c, obs, 14'h0);
      end
    end
    reset        = 1'b0;
    lookup_valid = 1'b0;
    step();
    n_checks++;
    if (obs !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_no_late_result: got %h expected %h", obs, 14'h0);
    end
  endtask

  task automatic test_single_hit();
    addr_tag = 12'hABC;
    for (int i = 0; i < WAYS; i++) set_tag(i, 12'h100 + 12'(i));
    set_tag(5, 12'hABC);
    way_valid    = 8'hFF;
    lookup_valid = 1'b1;
    step();
    lookup_valid = 1'b0;
    n_checks++;
    if (obs !== {1'b1, 1'b1, 3'd5, 8'h20, 1'b0}) begin
      n_fail++;
      $display("FAIL single_hit: got %h expected %h", obs, {1'b1, 1'b1, 3'd5, 8'h20, 1'b0});
    end
  endtask

  task automatic test_invalid_match();
    addr_tag = 12'h5A5;
    for (int i = 0; i < WAYS; i++) set_tag(i, 12'h200 + 12'(i));
    set_tag(2, 12'h5A5);
    way_valid    = 8'hFB;
    lookup_valid = 1'b1;
    step();
    lookup_valid = 1'b0;
    n_checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL invalid_match: got %h expected %h", obs, {1'b1, 1'b0, 3'd0, 8'h00, 1'b0});
    end
  endtask

  task automatic test_multi_hit();
    addr_tag = 12'h777;
    for (int i = 0; i < WAYS; i++) set_tag(i, 12'h300 + 12'(i));
    set_tag(3, 12'h777);
    set_tag(6, 12'h777);
    way_valid    = 8'hFF;
    lookup_valid = 1'b1;
    step();
    lookup_valid = 1'b0;
    n_checks++;
    if (obs !== {1'b1, 1'b1, 3'd3, 8'h48, 1'b1}) begin
      n_fail++;
      $display("FAIL multi_hit: got %h expected %h", obs, {1'b1, 1'b1, 3'd3, 8'h48, 1'b1});
    end
    // Results must disappear cleanly when the next lookup is a single hit.
    set_tag(3, 12'h000);
    lookup_valid = 1'b1;
    step();
    lookup_valid = 1'b0;
    n_checks++;
    if (obs !== {1'b1, 1'b1, 3'd6, 8'h40, 1'b0}) begin
      n_fail++;
      $display("FAIL multi_hit_cleared: got %h expected %h", obs, {1'b1, 1'b1, 3'd6, 8'h40, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < WAYS; i++) set_tag(i, 12'h400 + 12'(i));
    way_valid    = 8'hFF;
    lookup_valid = 1'b1;
    addr_tag     = 12'h407;
    step();
    n_checks++;
    if (obs !== {1'b1, 1'b1, 3'd7, 8'h80, 1'b0}) begin
      n_fail++;
      $display("FAIL stream_hit7: got %h expected %h", obs, {1'b1, 1'b1, 3'd7, 8'h80, 1'b0});
    end
    addr_tag = 12'hBEE;
    step();
    n_checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL stream_miss: got %h expected %h", obs, {1'b1, 1'b0, 3'd0, 8'h00, 1'b0});
    end
    addr_tag = 12'h400;
    step();
    n_checks++;
    if (obs !== {1'b1, 1'b1, 3'd0, 8'h01, 1'b0}) begin
      n_fail++;
      $display("FAIL stream_hit0: got %h expected %h", obs, {1'b1, 1'b1, 3'd0, 8'h01, 1'b0});
    end
    // Idle with a would-be hit on the inputs: outputs must hold, not update.
    lookup_valid = 1'b0;
    addr_tag     = 12'h404;
    step();
    n_checks++;
    if (obs !== {1'b0, 1'b1, 3'd0, 8'h01, 1'b0}) begin
      n_fail++;
      $display("FAIL stream_hold1: got %h expected %h", obs, {1'b0, 1'b1, 3'd0, 8'h01, 1'b0});
    end
    step();
    n_checks++;
    if (obs !== {1'b0, 1'b1, 3'd0, 8'h01, 1'b0}) begin
      n_fail++;
      $display("FAIL stream_hold2: got %h expected %h", obs, {1'b0, 1'b1, 3'd0, 8'h01, 1'b0});
    end
  endtask

  task automatic test_boundary();
    addr_tag = 12'hFFF;
    set_all_tags(12'hFFE);
    way_valid    = 8'hFF;
    lookup_valid = 1'b1;
    step();
    n_checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL boundary_fff_miss: got %h expected %h", obs, {1'b1, 1'b0, 3'd0, 8'h00, 1'b0});
    end
    addr_tag = 12'h000;
    set_all_tags(12'h800);
    set_tag(0, 12'h000);
    step();
    n_checks++;
    if (obs !== {1'b1, 1'b1, 3'd0, 8'h01, 1'b0}) begin
      n_fail++;
      $display("FAIL boundary_zero_hit: got %h expected %h", obs, {1'b1, 1'b1, 3'd0, 8'h01, 1'b0});
    end
    // All ways match: lowest index still wins and multi-hit flags.
    addr_tag = 12'hFFF;
    set_all_tags(12'hFFF);
    step();
    lookup_valid = 1'b0;
    n_checks++;
    if (obs !== {1'b1, 1'b1, 3'd0, 8'hFF, 1'b1}) begin
      n_fail++;
      $display("FAIL boundary_all_match: got %h expected %h", obs, {1'b1, 1'b1, 3'd0, 8'hFF, 1'b1});
    end
  endtask

  task automatic test_reset_mid_run();
    addr_tag = 12'h0F0;
    set_all_tags(12'h0F0);
    way_valid    = 8'h10;
    lookup_valid = 1'b1;
    reset        = 1'b1;
    step();
    reset        = 1'b0;
    lookup_valid = 1'b0;
    n_checks++;
    if (obs !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_priority: got %h expected %h", obs, 14'h0);
    end
    lookup_valid = 1'b1;
    step();
    lookup_valid = 1'b0;
    n_checks++;
    if (obs !== {1'b1, 1'b1, 3'd4, 8'h10, 1'b0}) begin
      n_fail++;
      $display("FAIL after_reset_hit4: got %h expected %h", obs, {1'b1, 1'b1, 3'd4, 8'h10, 1'b0});
    end
  endtask

  initial begin
    reset        = 1'b1;
    lookup_valid = 1'b0;
    addr_tag     = '0;
    way_tags     = '0;
    way_valid    = '0;
    test_reset();
    test_single_hit();
    test_invalid_match();
    test_multi_hit();
    test_back_to_back();
    test_boundary();
    test_reset_mid_run();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
